util_axis_uart_tx_arbiter: RTL and testbench

UTIL_AXIS_UART_TX_ARBITER -- requirements
Module: util_axis_uart_tx_arbiter

---
 rtl/util_axis_uart_tx_arbiter.sv | 123 ++++++++++++
 tb/tb_util_axis_uart_tx_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/util_axis_uart_tx_arbiter.sv
// Round-robin arbiter that funnels several AXI-Stream byte sources into one UART tx port.
// A grant lasts one packet (tlast) or max_burst beats, with one IDLE cycle between grants.
module util_axis_uart_tx_arbiter #(
  parameter int num_requesters = 2,
  parameter int data_bits      = 8,
  parameter int max_burst      = 16
) (
  input  logic                                aclk,
  input  logic                                arstn,
  input  logic [num_requesters*data_bits-1:0] s_axis_tdata,
  input  logic [num_requesters-1:0]           s_axis_tvalid,
  input  logic [num_requesters-1:0]           s_axis_tlast,
  output logic [num_requesters-1:0]           s_axis_tready,
  output logic [data_bits-1:0]                m_axis_tdata,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic [$clog2(num_requesters)-1:0]   grant_id,
  output logic                                grant_active
);
  localparam int IDW = $clog2(num_requesters);
  localparam int CW  = $clog2(max_burst + 1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(max_burst - 1);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(num_requesters - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state, state_nxt;
  logic [1:0]          rst_pipe;
  logic                rst_n;
  logic [IDW-1:0]      last_grant;
  logic [IDW-1:0]      winner;
  logic [CW-1:0]       beat_cnt;
  logic                any_req;
  logic [data_bits-1:0] sel_data;
  logic                sel_valid;
  logic                sel_last;
  logic                beat;
  logic                last_beat;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) rst_pipe <= '0;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  // Smallest distance from last_grant+1 (mod N) wins.
  always_comb begin
    int best_off;
    int off;
    winner   = last_grant;
    best_off = num_requesters;
    off      = 0;
    for (int i = 0; i < num_requesters; i++) begin
      off = (i + num_requesters - 1 - int'(last_grant)) % num_requesters;
      if (s_axis_tvalid[i] && off < best_off) begin
        best_off = off;
        winner   = IDW'(i);
      end
    end
  end

  assign any_req = |s_axis_tvalid;

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < num_requesters; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_data  = s_axis_tdata[i*data_bits +: data_bits];
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
      end
    end
  end

  assign beat      = (state == GRANT) && sel_valid && m_axis_tready;
  assign last_beat = beat && (sel_last || beat_cnt == LAST_CNT);

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)   state_nxt = GRANT;
      GRANT:   if (last_beat) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_active  = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    s_axis_tready = '0;
    if (state == GRANT) begin
      grant_active  = 1'b1;
      m_axis_tvalid = sel_valid;
      m_axis_tdata  = sel_data;
      for (int i = 0; i < num_requesters; i++)
        s_axis_tready[i] = (grant_id == IDW'(i)) && m_axis_tready;
    end
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id   <= '0;
      last_grant <= LAST_ID;
      beat_cnt   <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        grant_id <= winner;
        beat_cnt <= '0;
      end
      if (beat)      beat_cnt   <= beat_cnt + CW'(1);
      if (last_beat) last_grant <= grant_id;
    end
  end
endmodule

// File: tb/tb_util_axis_uart_tx_arbiter.sv
// Directed bench for the UART tx arbiter: per-requester beat queues feed the DUT,
// a negedge monitor records every accepted output beat with its grant_id and cycle.
module tb_util_axis_uart_tx_arbiter;
  localparam int NR = 2;
  localparam int DB = 8;
  localparam int MB = 16;

  logic               aclk;
  logic               arstn;
  logic [NR*DB-1:0]   s_axis_tdata;
  logic [NR-1:0]      s_axis_tvalid;
  logic [NR-1:0]      s_axis_tlast;
  logic [NR-1:0]      s_axis_tready;
  logic [DB-1:0]      m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic [0:0]         grant_id;
  logic               grant_active;

  util_axis_uart_tx_arbiter #(.num_requesters(NR), .data_bits(DB), .max_burst(MB)) dut (
    .aclk(aclk), .arstn(arstn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .grant_id(grant_id), .grant_active(grant_active)
  );

  typedef struct {logic [7:0] d; logic l; int gap;} beat_t;
  typedef struct {logic [7:0] d; int id; int cyc;} obs_t;

  beat_t q0[$];
  beat_t q1[$];
  obs_t  got[$];
  int    checks = 0;
  int    fails  = 0;
  int    cyc    = 0;
  logic  tgl = 1'b0;
  logic  hold_bad = 1'b0;
  logic  stall_pend = 1'b0;
  logic  multi_rdy = 1'b0;
  logic [7:0]    stall_d = '0;
  logic [NR-1:0] hs;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic push(input int r, input logic [7:0] d, input logic l, input int gap);
    beat_t b;
    b.d = d; b.l = l; b.gap = gap;
    if (r == 0) q0.push_back(b);
    else        q1.push_back(b);
  endtask

  function automatic obs_t at(input int i);
    obs_t o;
    o.d = 8'h00; o.id = -1; o.cyc = -1;
    if (i < got.size()) o = got[i];
    return o;
  endfunction

  task automatic present;
    beat_t b;
    if (q0.size() > 0 && q0[0].gap > 0) begin
      b = q0[0]; b.gap--; q0[0] = b; s_axis_tvalid[0] = 1'b0;
    end else if (q0.size() > 0) begin
      s_axis_tvalid[0] = 1'b1; s_axis_tdata[7:0] = q0[0].d; s_axis_tlast[0] = q0[0].l;
    end else begin
      s_axis_tvalid[0] = 1'b0; s_axis_tlast[0] = 1'b0;
    end
    if (q1.size() > 0 && q1[0].gap > 0) begin
      b = q1[0]; b.gap--; q1[0] = b; s_axis_tvalid[1] = 1'b0;
    end else if (q1.size() > 0) begin
      s_axis_tvalid[1] = 1'b1; s_axis_tdata[15:8] = q1[0].d; s_axis_tlast[1] = q1[0].l;
    end else begin
      s_axis_tvalid[1] = 1'b0; s_axis_tlast[1] = 1'b0;
    end
  endtask

  // Source driver + output monitor; sample at negedge, update inputs 1 time unit after posedge.
  initial begin
    s_axis_tdata  = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 1'b1;
    forever begin
      @(negedge aclk);
      cyc++;
      hs = s_axis_tvalid & s_axis_tready;
      if (m_axis_tvalid && m_axis_tready) got.push_back('{m_axis_tdata, int'(grant_id), cyc});
      if (stall_pend && (!m_axis_tvalid || m_axis_tdata !== stall_d)) hold_bad = 1'b1;
      stall_pend = m_axis_tvalid && !m_axis_tready;
      stall_d    = m_axis_tdata;
      if ($countones(s_axis_tready) > 1) multi_rdy = 1'b1;
      @(posedge aclk);
      #1;
      if (hs[0] && q0.size() > 0) void'(q0.pop_front());
      if (hs[1] && q1.size() > 0) void'(q1.pop_front());
      present();
      m_axis_tready = tgl ? ~m_axis_tready : 1'b1;
    end
  end

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || grant_active) && n < 500) begin
      @(negedge aclk);
      n++;
    end
    checks++;
    if (n >= 500) begin
      fails++;
      $display("FAIL %s drain: timed out with q0=%0d q1=%0d beats left", nm, q0.size(), q1.size());
    end
    repeat (3) @(posedge aclk);
    #1;
  endtask

  task automatic test_reset;
    arstn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    checks += 4;
    if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid got %b want 0", m_axis_tvalid); end
    if (s_axis_tready !== 2'b00) begin fails++; $display("FAIL rst_tready got %b want 00", s_axis_tready); end
    if (grant_active !== 1'b0) begin fails++; $display("FAIL rst_active got %b want 0", grant_active); end
    if (grant_id !== 1'b0) begin fails++; $display("FAIL rst_grant_id got %0d want 0", grant_id); end
    arstn = 1'b1;
    repeat (4) @(posedge aclk);
    #1;
    checks++;
    if (grant_active !== 1'b0) begin fails++; $display("FAIL idle_no_req active got %b want 0", grant_active); end
  endtask

  task automatic test_two_packets;
    int base;
    obs_t o, a, b;
    logic [7:0] ed [6];
    int ei [6];
    ed = '{8'h41, 8'h42, 8'h43, 8'h61, 8'h62, 8'h63};
    ei = '{0, 0, 0, 1, 1, 1};
    base = got.size();
    push(0, 8'h41, 1'b0, 0); push(0, 8'h42, 1'b0, 0); push(0, 8'h43, 1'b1, 0);
    push(1, 8'h61, 1'b0, 0); push(1, 8'h62, 1'b0, 0); push(1, 8'h63, 1'b1, 0);
    wait_drain("two_pkt");
    checks++;
    if (got.size() - base != 6) begin fails++; $display("FAIL two_pkt count got %0d want 6", got.size() - base); end
    for (int k = 0; k < 6; k++) begin
      o = at(base + k);
      checks++;
      if (o.d !== ed[k] || o.id != ei[k]) begin
        fails++; $display("FAIL two_pkt beat%0d got %h/id%0d want %h/id%0d", k, o.d, o.id, ed[k], ei[k]);
      end
    end
    a = at(base); b = at(base + 2);
    checks++;
    if (b.cyc - a.cyc != 2) begin fails++; $display("FAIL two_pkt contiguous span got %0d want 2", b.cyc - a.cyc); end
    a = at(base + 3);
    checks++;
    if (a.cyc - b.cyc != 2) begin fails++; $display("FAIL two_pkt idle_gap got %0d want 2", a.cyc - b.cyc); end
  endtask

  task automatic test_max_burst;
    int base;
    obs_t o, a, b;
    logic [7:0] e;
    int ei;
    // 20 beats, tlast only on the last: max_burst cuts after 16, requester 1 regranted.
    base = got.size();
    for (int k = 0; k < 20; k++) push(1, 8'hC0 + 8'(k), k == 19, 0);
    wait_drain("burst");
    checks++;
    if (got.size() - base != 20) begin fails++; $display("FAIL burst count got %0d want 20", got.size() - base); end
    for (int k = 0; k < 20; k++) begin
      o = at(base + k); e = 8'hC0 + 8'(k);
      checks++;
      if (o.d !== e || o.id != 1) begin fails++; $display("FAIL burst beat%0d got %h/id%0d want %h/id1", k, o.d, o.id, e); end
    end
    a = at(base + 15); b = at(base + 16);
    checks++;
    if (b.cyc - a.cyc != 2) begin fails++; $display("FAIL burst release_gap got %0d want 2", b.cyc - a.cyc); end
    a = at(base);
    checks++;
    if (at(base + 15).cyc - a.cyc != 15) begin fails++; $display("FAIL burst span got %0d want 15", at(base + 15).cyc - a.cyc); end

    // Requester 0 shows up mid-burst: it gets the next grant, then requester 1 finishes.
    base = got.size();
    for (int k = 0; k < 18; k++) push(1, 8'hA0 + 8'(k), k == 17, 0);
    repeat (5) @(posedge aclk);
    #1;
    push(0, 8'h01, 1'b1, 0);
    wait_drain("burst_rr");
    for (int k = 0; k < 19; k++) begin
      o = at(base + k);
      if (k < 16)       begin e = 8'hA0 + 8'(k);     ei = 1; end
      else if (k == 16) begin e = 8'h01;              ei = 0; end
      else              begin e = 8'hA0 + 8'(k - 1); ei = 1; end
      checks++;
      if (o.d !== e || o.id != ei) begin fails++; $display("FAIL burst_rr beat%0d got %h/id%0d want %h/id%0d", k, o.d, o.id, e, ei); end
    end
  endtask

  task automatic test_burst_tlast;
    int base;
    obs_t o, a, b;
    logic [7:0] e;
    base = got.size();
    for (int k = 0; k < 16; k++) push(1, 8'hD0 + 8'(k), k == 15, 0);
    push(1, 8'hE0, 1'b0, 0); push(1, 8'hE1, 1'b1, 0);
    wait_drain("tlast_max");
    checks++;
    if (got.size() - base != 18) begin fails++; $display("FAIL tlast_max count got %0d want 18", got.size() - base); end
    for (int k = 0; k < 18; k++) begin
      o = at(base + k);
      e = (k < 16) ? 8'hD0 + 8'(k) : 8'hE0 + 8'(k - 16);
      checks++;
      if (o.d !== e || o.id != 1) begin fails++; $display("FAIL tlast_max beat%0d got %h/id%0d want %h/id1", k, o.d, o.id, e); end
    end
    a = at(base + 15); b = at(base + 16);
    checks++;
    if (b.cyc - a.cyc != 2) begin fails++; $display("FAIL tlast_max gap got %0d want 2", b.cyc - a.cyc); end
  endtask

  task automatic test_tready_toggle;
    int base;
    obs_t o;
    logic [7:0] e;
    base = got.size();
    hold_bad = 1'b0;
    tgl = 1'b1;
    for (int k = 0; k < 4; k++) push(0, 8'h10 + 8'(k), k == 3, 0);
    wait_drain("toggle");
    tgl = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    checks++;
    if (got.size() - base != 4) begin fails++; $display("FAIL toggle count got %0d want 4", got.size() - base); end
    for (int k = 0; k < 4; k++) begin
      o = at(base + k); e = 8'h10 + 8'(k);
      checks++;
      if (o.d !== e || o.id != 0) begin fails++; $display("FAIL toggle beat%0d got %h/id%0d want %h/id0", k, o.d, o.id, e); end
    end
    checks++;
    if (hold_bad !== 1'b0) begin fails++; $display("FAIL toggle hold_stable got unstable want stable"); end
  endtask

  task automatic test_stall;
    int base;
    obs_t o, a, b;
    logic [7:0] ed [5];
    int ei [5];
    ed = '{8'h71, 8'h72, 8'h73, 8'h01, 8'h02};
    ei = '{1, 1, 1, 0, 0};
    base = got.size();
    push(1, 8'h71, 1'b0, 0); push(1, 8'h72, 1'b0, 5); push(1, 8'h73, 1'b1, 0);
    push(0, 8'h01, 1'b0, 0); push(0, 8'h02, 1'b1, 0);
    wait_drain("stall");
    for (int k = 0; k < 5; k++) begin
      o = at(base + k);
      checks++;
      if (o.d !== ed[k] || o.id != ei[k]) begin
        fails++; $display("FAIL stall beat%0d got %h/id%0d want %h/id%0d", k, o.d, o.id, ed[k], ei[k]);
      end
    end
    a = at(base); b = at(base + 1);
    checks++;
    if (b.cyc - a.cyc != 6) begin fails++; $display("FAIL stall hold_gap got %0d want 6", b.cyc - a.cyc); end
  endtask

  task automatic test_reset_mid;
    int base, n;
    obs_t o;
    logic [7:0] ed [5];
    int ei [5];
    ed = '{8'h91, 8'h92, 8'h82, 8'h83, 8'h84};
    ei = '{0, 0, 1, 1, 1};
    base = got.size();
    push(1, 8'h81, 1'b0, 0); push(1, 8'h82, 1'b0, 0); push(1, 8'h83, 1'b0, 0); push(1, 8'h84, 1'b1, 0);
    push(0, 8'h91, 1'b0, 0); push(0, 8'h92, 1'b1, 0);
    n = 0;
    while (got.size() == base && n < 100) begin @(posedge aclk); n++; end
    #1;
    arstn = 1'b0;
    #1;
    checks += 5;
    if (at(base).d !== 8'h81 || at(base).id != 1) begin fails++; $display("FAIL rstmid first got %h/id%0d want 81/id1", at(base).d, at(base).id); end
    if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL rstmid tvalid got %b want 0", m_axis_tvalid); end
    if (s_axis_tready !== 2'b00) begin fails++; $display("FAIL rstmid tready got %b want 00", s_axis_tready); end
    if (grant_active !== 1'b0) begin fails++; $display("FAIL rstmid active got %b want 0", grant_active); end
    if (grant_id !== 1'b0) begin fails++; $display("FAIL rstmid grant_id got %0d want 0", grant_id); end
    @(posedge aclk);
    #1;
    arstn = 1'b1;
    wait_drain("rstmid");
    checks++;
    if (got.size() - base != 6) begin fails++; $display("FAIL rstmid count got %0d want 6", got.size() - base); end
    for (int k = 0; k < 5; k++) begin
      o = at(base + 1 + k);
      checks++;
      if (o.d !== ed[k] || o.id != ei[k]) begin
        fails++; $display("FAIL rstmid beat%0d got %h/id%0d want %h/id%0d", k, o.d, o.id, ed[k], ei[k]);
      end
    end
  endtask

  initial begin
    arstn = 1'b0;
    test_reset();
    test_two_packets();
    test_max_burst();
    test_burst_tlast();
    test_tready_toggle();
    test_stall();
    test_reset_mid();
    checks++;
    if (multi_rdy !== 1'b0) begin fails++; $display("FAIL onehot_ready got multiple want at most one"); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
